// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin arbiter sharing one combinational ALU between two requesters
// Optional grant counters enabled by macro ALU_ARBITER_CNT_EN.
module alu_arbiter #(
  parameter bit RR_INIT = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        r0_valid,
  output logic        r0_ready,
  input  logic [15:0] r0_A,
  input  logic [15:0] r0_B,
  input  logic        r0_invA,
  input  logic        r0_invB,
  input  logic        r0_cin,
  input  logic [3:0]  r0_mode,
  input  logic        r1_valid,
  output logic        r1_ready,
  input  logic [15:0] r1_A,
  input  logic [15:0] r1_B,
  input  logic        r1_invA,
  input  logic        r1_invB,
  input  logic        r1_cin,
  input  logic [3:0]  r1_mode,
  output logic [15:0] alu_A,
  output logic [15:0] alu_B,
  output logic        alu_invA,
  output logic        alu_invB,
  output logic        alu_cin,
  output logic [3:0]  alu_mode,
  input  logic [15:0] alu_out,
  output logic        res_valid,
  input  logic        res_ready,
  output logic        res_id,
  output logic [15:0] res_data,
  output logic [15:0] grant0_cnt,
  output logic [15:0] grant1_cnt
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t state;
  logic   rr;
  logic   sel;
  logic   take;

  // sel names the winner: the sole valid requester, or rr when both are valid
  always_comb begin
    sel  = (r0_valid && r1_valid) ? rr : r1_valid;
    take = !rst && (state == IDLE) && (r0_valid || r1_valid);
  end

  assign r0_ready = take && !sel;
  assign r1_ready = take && sel;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rr        <= RR_INIT;
      alu_A     <= 16'h0000;
      alu_B     <= 16'h0000;
      alu_invA  <= 1'b0;
      alu_invB  <= 1'b0;
      alu_cin   <= 1'b0;
      alu_mode  <= 4'h0;
      res_valid <= 1'b0;
      res_id    <= 1'b0;
      res_data  <= 16'h0000;
    end else begin
      case (state)
        IDLE: begin
          if (take) begin
            alu_A    <= sel ? r1_A    : r0_A;
            alu_B    <= sel ? r1_B    : r0_B;
            alu_invA <= sel ? r1_invA : r0_invA;
            alu_invB <= sel ? r1_invB : r0_invB;
            alu_cin  <= sel ? r1_cin  : r0_cin;
            alu_mode <= sel ? r1_mode : r0_mode;
            res_id   <= sel;
            // Priority always moves to the requester that was not served
            rr       <= ~sel;
            state    <= EXEC;
          end
        end
        EXEC: begin
          res_data  <= alu_out;
          res_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ALU_ARBITER_CNT_EN
  logic [15:0] cnt0;
  logic [15:0] cnt1;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt0 <= 16'h0000;
      cnt1 <= 16'h0000;
    end else begin
      if (r0_valid && r0_ready && cnt0 != 16'hFFFF) cnt0 <= cnt0 + 16'h0001;
      if (r1_valid && r1_ready && cnt1 != 16'hFFFF) cnt1 <= cnt1 + 16'h0001;
    end
  end

  assign grant0_cnt = cnt0;
  assign grant1_cnt = cnt1;
`else
  assign grant0_cnt = 16'h0000;
  assign grant1_cnt = 16'h0000;
`endif

endmodule
